wifi_dma_handshake: RTL
=======================

Name: wifi_dma_handshake

Overview:
- Sequences DMA traffic for the WiFi PHY peripheral.
- Consumes the peripheral's level-type DMA_WRITE_REQ / DMA_READ_REQ.
- Arbitrates between the TX channel (memory->WiFi FIFO) and the RX channel (WiFi FIFO->memory).
- Issues bounded bursts to the system DMA engine and returns ACK/DONE pulses to the peripheral.
- Sits directly between the WiFi AHB peripheral and the DMA engine, on HCLK.

Parameters:
- LEN_WIDTH, 8: width of the per-channel transfer length in beats.
- BURST_BEATS, 4: maximum beats per engine burst; must be >= 1.
- TIMEOUT, 255: cycles allowed in XFER before abort; must be >= 1.

Ports:
- HCLK  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- cfg_load  in  1  pulse; loads both remaining counters and clears timeout_err.
- cfg_enable  in  1  level; permits new grants.
- cfg_wr_len  in  LEN_WIDTH  TX transfer length in beats.
- cfg_rd_len  in  LEN_WIDTH  RX transfer length in beats.
- DMA_WRITE_REQ  in  1  peripheral requests TX data (level).
- DMA_READ_REQ  in  1  peripheral has RX data (level).
- DMA_WRITE_ACK  out  1  one-cycle grant pulse, TX.
- DMA_READ_ACK  out  1  one-cycle grant pulse, RX.
- DMA_WRITE_DONE  out  1  one-cycle pulse; TX length exhausted.
- DMA_READ_DONE  out  1  one-cycle pulse; RX length exhausted.
- eng_start  out  1  one-cycle burst start to the DMA engine.
- eng_dir  out  1  0 = TX, 1 = RX; held from eng_start until the burst ends.
- eng_beats  out  clog2(BURST_BEATS)+1  beats in the current burst; held.
- eng_done  in  1  pulse from the engine: burst complete.
- eng_abort  out  1  one-cycle pulse on timeout.
- busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  sticky error flag.

Behaviour:
- Clock and reset: single clock HCLK. Reset is synchronous and active-high.
- Reset values: all outputs 0, both remaining counters 0, timeout counter 0, last_served = TX, state IDLE.
- States: IDLE, GRANT, XFER, FINISH.
- IDLE, load:
  - cfg_load loads wr_rem <= cfg_wr_len and rd_rem <= cfg_rd_len, and clears timeout_err.
  - cfg_load outside IDLE is ignored entirely.
  - If cfg_load coincides with a grant decision, the load wins and no grant occurs that cycle.
- IDLE, eligibility:
  - A channel is eligible when cfg_enable=1, its REQ=1 and its rem != 0.
  - If both are eligible, grant the channel not in last_served (round-robin). The first tie after reset therefore goes to RX.
  - If only one is eligible, grant it.
  - On a grant: latch dir and beats = min(BURST_BEATS, rem), update last_served, go to GRANT.
- GRANT (exactly 1 cycle):
  - Assert eng_start and the ACK of the granted channel.
  - eng_dir and eng_beats are valid from this cycle.
  - Clear the timeout counter, then go to XFER.
  - Latency: REQ sampled in IDLE at cycle N -> ACK and eng_start high at cycle N+1.
- XFER:
  - The timeout counter increments each cycle.
  - On eng_done: rem <= rem - beats, go to FINISH.
  - If the counter reaches TIMEOUT without eng_done: pulse eng_abort, set timeout_err, zero the active channel's rem, emit no DONE, go to IDLE.
  - An eng_done arriving in the same cycle as expiry counts as completion, not a timeout.
- FINISH (1 cycle):
  - If the active channel's rem == 0, pulse its DONE.
  - Go to IDLE.
  - eng_done at cycle M -> DONE at M+1; the earliest next grant is M+2.
- Other boundary rules:
  - eng_done outside XFER is ignored.
  - Length 0: the channel is never granted and never emits DONE.
  - Subtraction never underflows because beats <= rem.
  - cfg_enable dropped mid-burst: the current burst completes normally, including DONE; no new grants follow.
  - REQ dropping after a grant does not cancel the burst; REQ is only sampled in IDLE.
  - reset mid-operation returns to IDLE with all outputs 0; the engine is not notified (the system reset clears it).
- Output style: all outputs are registered; no combinational path from any input to any output.

Decomposition:
- Shared package: state encoding (IDLE/GRANT/XFER/FINISH), direction constants (DIR_TX = 0, DIR_RX = 1), and the beats-width function.
- One natural sub-module, wifi_dma_chan_cnt, instantiated twice (TX, RX). It holds:
  - the load behaviour,
  - the remaining counter with subtract-by-beats,
  - the min(BURST_BEATS, rem) computation,
  - the zero flag.
- Arbitration, the FSM and the timeout counter stay in the top level.

Test Plan:
- Single TX: cfg_wr_len = 10, load, enable, hold DMA_WRITE_REQ, engine returns eng_done 3 cycles after each eng_start -> bursts of 4, 4, 2 beats with eng_dir = 0; DMA_WRITE_DONE pulses once, the cycle after the third eng_done; wr_rem = 0.
- Round-robin: wr_len = rd_len = 8, both REQs held -> grant order RX, TX, RX, TX; each DONE pulses exactly once.
- Timeout: TIMEOUT = 5, grant TX, never return eng_done -> eng_abort pulses 5 cycles into XFER; timeout_err = 1; no DONE; wr_rem = 0. A following cfg_load clears timeout_err.
- Zero length: rd_len = 0, DMA_READ_REQ held 50 cycles -> no ACK, no eng_start, busy stays 0.
- Enable drop: cfg_enable deasserted during XFER of a 4-beat TX burst with rem = 4 -> the burst completes, DMA_WRITE_DONE pulses, and no further grants occur while REQs stay high.
- Reset mid-XFER: assert reset for 1 cycle -> the next cycle shows all outputs 0, state IDLE, rem = 0, and a late eng_done is ignored.

Source files
------------

// File: rtl/wifi_dma_handshake_pkg.sv
// rtl/wifi_dma_handshake_pkg.sv - shared state encoding, direction constants and beat-width helper
package wifi_dma_handshake_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        XFER   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic DIR_TX = 1'b0;
    localparam logic DIR_RX = 1'b1;

    function automatic int beats_w(input int burst_beats);
        return $clog2(burst_beats) + 1;
    endfunction

endpackage

// File: rtl/wifi_dma_handshake_if.sv
// rtl/wifi_dma_handshake_if.sv - peripheral and DMA-engine handshake bundle
interface wifi_dma_handshake_if #(
    parameter int BURST_BEATS = 4
);
    localparam int BW = wifi_dma_handshake_pkg::beats_w(BURST_BEATS);

    logic          DMA_WRITE_REQ;
    logic          DMA_READ_REQ;
    logic          DMA_WRITE_ACK;
    logic          DMA_READ_ACK;
    logic          DMA_WRITE_DONE;
    logic          DMA_READ_DONE;
    logic          eng_start;
    logic          eng_dir;
    logic [BW-1:0] eng_beats;
    logic          eng_done;
    logic          eng_abort;

    modport slave (
        input  DMA_WRITE_REQ, DMA_READ_REQ, eng_done,
        output DMA_WRITE_ACK, DMA_READ_ACK, DMA_WRITE_DONE, DMA_READ_DONE,
        output eng_start, eng_dir, eng_beats, eng_abort
    );

    modport master (
        output DMA_WRITE_REQ, DMA_READ_REQ, eng_done,
        input  DMA_WRITE_ACK, DMA_READ_ACK, DMA_WRITE_DONE, DMA_READ_DONE,
        input  eng_start, eng_dir, eng_beats, eng_abort
    );

endinterface

// File: rtl/wifi_dma_chan_cnt.sv
// rtl/wifi_dma_chan_cnt.sv - per-channel remaining-beat counter with burst sizing
module wifi_dma_chan_cnt
    import wifi_dma_handshake_pkg::*;
#(
    parameter int LEN_WIDTH   = 8,
    parameter int BURST_BEATS = 4,
    parameter int BW          = beats_w(BURST_BEATS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 sub,
    input  logic [BW-1:0]        sub_beats,
    input  logic                 clr,
    output logic [BW-1:0]        burst,
    output logic                 zero,
    output logic                 final_burst
);
    logic [LEN_WIDTH-1:0] rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            rem <= '0;
        end else if (load) begin
            rem <= len;
        end else if (clr) begin
            rem <= '0;
        end else if (sub) begin
            rem <= rem - LEN_WIDTH'(sub_beats);
        end
    end

    // rem is untouched between grant and subtract, so final_burst also means rem == granted beats
    always_comb begin
        burst       = (int'(rem) >= BURST_BEATS) ? BW'(BURST_BEATS) : BW'(rem);
        zero        = (rem == '0);
        final_burst = (int'(rem) <= BURST_BEATS);
    end

endmodule

// File: rtl/wifi_dma_handshake.sv
// rtl/wifi_dma_handshake.sv - TX/RX DMA arbitration and burst sequencing for the WiFi PHY
module wifi_dma_handshake
    import wifi_dma_handshake_pkg::*;
#(
    parameter int LEN_WIDTH   = 8,
    parameter int BURST_BEATS = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                 HCLK,
    input  logic                 reset,
    input  logic                 cfg_load,
    input  logic                 cfg_enable,
    input  logic [LEN_WIDTH-1:0] cfg_wr_len,
    input  logic [LEN_WIDTH-1:0] cfg_rd_len,
    wifi_dma_handshake_if.slave  bus,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int BW = beats_w(BURST_BEATS);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_n;
    logic          last, last_n, dir_n, pick, load;
    logic [BW-1:0] beats_n, tx_burst, rx_burst;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          tx_zero, rx_zero, tx_final, rx_final, tx_elig, rx_elig;
    logic          tx_sub, rx_sub, tx_clr, rx_clr;
    logic          wr_ack_n, rd_ack_n, wr_done_n, rd_done_n, start_n, abort_n, err_n;

    assign load    = cfg_load && (state == IDLE);
    assign tx_elig = cfg_enable && bus.DMA_WRITE_REQ && !tx_zero;
    assign rx_elig = cfg_enable && bus.DMA_READ_REQ && !rx_zero;
    assign pick    = (rx_elig && (!tx_elig || last == DIR_TX)) ? DIR_RX : DIR_TX;

    wifi_dma_chan_cnt #(.LEN_WIDTH(LEN_WIDTH), .BURST_BEATS(BURST_BEATS)) u_tx (
        .clk(HCLK), .reset(reset), .load(load), .len(cfg_wr_len),
        .sub(tx_sub), .sub_beats(bus.eng_beats), .clr(tx_clr),
        .burst(tx_burst), .zero(tx_zero), .final_burst(tx_final)
    );

    wifi_dma_chan_cnt #(.LEN_WIDTH(LEN_WIDTH), .BURST_BEATS(BURST_BEATS)) u_rx (
        .clk(HCLK), .reset(reset), .load(load), .len(cfg_rd_len),
        .sub(rx_sub), .sub_beats(bus.eng_beats), .clr(rx_clr),
        .burst(rx_burst), .zero(rx_zero), .final_burst(rx_final)
    );

    always_comb begin
        state_n   = state;
        last_n    = last;
        dir_n     = bus.eng_dir;
        beats_n   = bus.eng_beats;
        tcnt_n    = tcnt;
        err_n     = timeout_err;
        wr_ack_n  = 1'b0;
        rd_ack_n  = 1'b0;
        wr_done_n = 1'b0;
        rd_done_n = 1'b0;
        start_n   = 1'b0;
        abort_n   = 1'b0;
        tx_sub    = 1'b0;
        rx_sub    = 1'b0;
        tx_clr    = 1'b0;
        rx_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    err_n = 1'b0;
                end else if (tx_elig || rx_elig) begin
                    dir_n    = pick;
                    beats_n  = (pick == DIR_RX) ? rx_burst : tx_burst;
                    last_n   = pick;
                    start_n  = 1'b1;
                    wr_ack_n = (pick == DIR_TX);
                    rd_ack_n = (pick == DIR_RX);
                    state_n  = GRANT;
                end
            end
            GRANT: begin
                tcnt_n  = '0;
                state_n = XFER;
            end
            XFER: begin
                tcnt_n = tcnt + 1'b1;
                // completion takes priority over a simultaneous expiry
                if (bus.eng_done) begin
                    tx_sub    = (bus.eng_dir == DIR_TX);
                    rx_sub    = (bus.eng_dir == DIR_RX);
                    wr_done_n = (bus.eng_dir == DIR_TX) && tx_final;
                    rd_done_n = (bus.eng_dir == DIR_RX) && rx_final;
                    state_n   = FINISH;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    abort_n = 1'b1;
                    err_n   = 1'b1;
                    tx_clr  = (bus.eng_dir == DIR_TX);
                    rx_clr  = (bus.eng_dir == DIR_RX);
                    state_n = IDLE;
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (reset) begin
            state              <= IDLE;
            last               <= DIR_TX;
            tcnt               <= '0;
            bus.DMA_WRITE_ACK  <= 1'b0;
            bus.DMA_READ_ACK   <= 1'b0;
            bus.DMA_WRITE_DONE <= 1'b0;
            bus.DMA_READ_DONE  <= 1'b0;
            bus.eng_start      <= 1'b0;
            bus.eng_dir        <= DIR_TX;
            bus.eng_beats      <= '0;
            bus.eng_abort      <= 1'b0;
            busy               <= 1'b0;
            timeout_err        <= 1'b0;
        end else begin
            state              <= state_n;
            last               <= last_n;
            tcnt               <= tcnt_n;
            bus.DMA_WRITE_ACK  <= wr_ack_n;
            bus.DMA_READ_ACK   <= rd_ack_n;
            bus.DMA_WRITE_DONE <= wr_done_n;
            bus.DMA_READ_DONE  <= rd_done_n;
            bus.eng_start      <= start_n;
            bus.eng_dir        <= dir_n;
            bus.eng_beats      <= beats_n;
            bus.eng_abort      <= abort_n;
            busy               <= (state_n != IDLE);
            timeout_err        <= err_n;
        end
    end

endmodule
